// File: rtl/reg_file_pkg.sv
// Shared constants for the decode-stage register file.
// Optional feature macro used by the register file: REGFILE_BYPASS_EN.
package reg_file_pkg;

  localparam int          REG_COUNT      = 32;
  localparam int          REG_ADDR_W     = 5;
  localparam int          DEFAULT_DATA_W = 32;
  localparam logic [4:0]  REG_ZERO       = 5'd0;
  // Link register, referenced by the decoder for JAL/JALR.
  localparam logic [4:0]  REG_RA         = 5'd31;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the register file: zero-register check,
// optional write-through bypass (REGFILE_BYPASS_EN), and storage select.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]     regs_i [1:REG_COUNT-1],
`ifdef REGFILE_BYPASS_EN
  // wr_en_i is already qualified with reset deassertion by the top.
  input  logic                  wr_en_i,
  input  logic [REG_ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
`endif
  output logic [DATA_W-1:0]     data_o
);

  logic [DATA_W-1:0] stored;

  // Select the addressed storage entry; register 0 has no entry and yields 0.
  always_comb begin
    stored = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (addr_i == REG_ADDR_W'(i)) stored = regs_i[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-before-read: a pending write to this port's (nonzero) address wins.
  always_comb begin
    if (wr_en_i && (wr_addr_i != REG_ZERO) && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end else begin
      data_o = stored;
    end
  end
`else
  // No bypass: reads always see the committed contents.
  always_comb begin
    data_o = stored;
  end
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x DATA_W architectural register file: three combinational read ports,
// one clocked write port, r0 hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through bypass).
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] RegA1,
  input  logic [REG_ADDR_W-1:0] RegB1,
  input  logic [REG_ADDR_W-1:0] RegC1,
  output logic [DATA_W-1:0]     DataA1,
  output logic [DATA_W-1:0]     DataB1,
  output logic [DATA_W-1:0]     DataC1,
  input  logic [REG_ADDR_W-1:0] WriteReg1,
  input  logic [DATA_W-1:0]     WriteData1,
  input  logic                  Write1
);

  logic [DATA_W-1:0] regs_q [1:REG_COUNT-1];
  logic [DATA_W-1:0] regs_d [1:REG_COUNT-1];

  // Next-state: only the addressed nonzero register takes the write data.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (Write1 && (WriteReg1 == REG_ADDR_W'(i))) regs_d[i] = WriteData1;
    end
  end

  // Storage update; reset clears everything immediately and drops a coincident write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 1; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  // Bypass is suppressed while reset is asserted.
  assign wr_live = Write1 & RESET;
`endif

  reg_read_port #(.DATA_W(DATA_W)) u_port_a (
    .addr_i    (RegA1),
    .regs_i    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (wr_live),
    .wr_addr_i (WriteReg1),
    .wr_data_i (WriteData1),
`endif
    .data_o    (DataA1)
  );

  reg_read_port #(.DATA_W(DATA_W)) u_port_b (
    .addr_i    (RegB1),
    .regs_i    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (wr_live),
    .wr_addr_i (WriteReg1),
    .wr_data_i (WriteData1),
`endif
    .data_o    (DataB1)
  );

  reg_read_port #(.DATA_W(DATA_W)) u_port_c (
    .addr_i    (RegC1),
    .regs_i    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (wr_live),
    .wr_addr_i (WriteReg1),
    .wr_data_i (WriteData1),
`endif
    .data_o    (DataC1)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file; expectations come from a simple array model.
module tb_reg_file;

  logic        CLK;
  logic        RESET;
  logic [4:0]  RegA1, RegB1, RegC1;
  logic [31:0] DataA1, DataB1, DataC1;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Write1;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file #(.DATA_W(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RegA1      (RegA1),
    .RegB1      (RegB1),
    .RegC1      (RegC1),
    .DataA1     (DataA1),
    .DataB1     (DataB1),
    .DataC1     (DataC1),
    .WriteReg1  (WriteReg1),
    .WriteData1 (WriteData1),
    .Write1     (Write1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // What a read of addr should show right now, given model and pending inputs.
  function automatic logic [31:0] expect_rd(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (!RESET) return 32'd0;
    if (BYP && Write1 && WriteReg1 != 5'd0 && WriteReg1 == addr) return WriteData1;
    return model[addr];
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_A"}, DataA1, expect_rd(RegA1));
    check({tag, "_B"}, DataB1, expect_rd(RegB1));
    check({tag, "_C"}, DataC1, expect_rd(RegC1));
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    RegA1 = a; RegB1 = b; RegC1 = c;
    #1;
  endtask

  // Present a write, clock it, update the model; inputs driven mid-low phase.
  task automatic do_write(input logic [4:0] wa, input logic [31:0] wd, input logic we);
    Write1 = we; WriteReg1 = wa; WriteData1 = wd;
    @(posedge CLK);
    if (we && wa != 5'd0 && RESET) model[wa] = wd;
    #1;
    Write1 = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    RESET = 1'b0; Write1 = 1'b0; WriteReg1 = '0; WriteData1 = '0;
    RegA1 = '0; RegB1 = '0; RegC1 = '0;
    repeat (2) @(negedge CLK);
    set_rd(5'd0, 5'd5, 5'd31);
    check_ports("por");
    RESET = 1'b1;
    @(negedge CLK);

    // Reset mid-cycle after filling r5.
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    set_rd(5'd5, 5'd5, 5'd5);
    check("r5_filled", DataA1, 32'hDEADBEEF);
    @(negedge CLK); #2;
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    set_rd(5'd0, 5'd5, 5'd31);
    check("rst_async_A", DataA1, 32'd0);
    check("rst_async_B", DataB1, 32'd0);
    check("rst_async_C", DataC1, 32'd0);
    set_rd(5'd5, 5'd5, 5'd5);
    check("rst_async_r5", DataC1, 32'd0);
    // Writes while reset is held are ignored (and not bypassed).
    Write1 = 1'b1; WriteReg1 = 5'd5; WriteData1 = 32'hA5A5A5A5;
    #1;
    check("rst_no_bypass", DataA1, 32'd0);
    @(posedge CLK); #1;
    Write1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rst_write_ignored", DataA1, 32'd0);
    @(negedge CLK);

    // Basic write/read and Write1=0.
    do_write(5'd7, 32'h12345678, 1'b1);
    set_rd(5'd7, 5'd7, 5'd7);
    check_ports("wr7");
    check("wr7_const", DataB1, 32'h12345678);
    do_write(5'd7, 32'hFFFFFFFF, 1'b0);
    check("wr7_noen", DataC1, 32'h12345678);

    // Zero register, including the write cycle itself.
    set_rd(5'd0, 5'd0, 5'd0);
    Write1 = 1'b1; WriteReg1 = 5'd0; WriteData1 = 32'hFFFFFFFF;
    #1;
    check("r0_same_cycle", DataA1, 32'd0);
    do_write(5'd0, 32'hFFFFFFFF, 1'b1);
    check_ports("r0_after");

    // Same-cycle hazard on r3.
    do_write(5'd3, 32'h11, 1'b1);
    set_rd(5'd3, 5'd0, 5'd0);
    Write1 = 1'b1; WriteReg1 = 5'd3; WriteData1 = 32'h22;
    #1;
    check("haz_pre", DataA1, BYP ? 32'h22 : 32'h11);
    do_write(5'd3, 32'h22, 1'b1);
    check("haz_post", DataA1, 32'h22);

    // Port independence.
    do_write(5'd1, 32'd1, 1'b1);
    do_write(5'd2, 32'd2, 1'b1);
    do_write(5'd31, 32'h80000000, 1'b1);
    set_rd(5'd1, 5'd2, 5'd31);
    check("ind_A", DataA1, 32'd1);
    check("ind_B", DataB1, 32'd2);
    check("ind_C", DataC1, 32'h80000000);
    RegB1 = 5'd7; #1;
    check("ind2_A", DataA1, 32'd1);
    check("ind2_B", DataB1, 32'h12345678);
    check("ind2_C", DataC1, 32'h80000000);

    // Reset asserted on the same edge as a write to r9.
    @(negedge CLK);
    Write1 = 1'b1; WriteReg1 = 5'd9; WriteData1 = 32'h55;
    @(posedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    Write1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    set_rd(5'd9, 5'd9, 5'd9);
    check("rst_edge_r9", DataA1, 32'd0);
    // First edge after release accepts a write.
    do_write(5'd9, 32'h66, 1'b1);
    check("first_after_rst", DataB1, 32'h66);

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        RegA1 = wa; RegB1 = 5'($urandom_range(0, 31)); RegC1 = 5'($urandom_range(0, 31));
      end else begin
        RegA1 = 5'($urandom_range(0, 31)); RegB1 = wa; RegC1 = 5'($urandom_range(0, 3));
      end
      Write1 = ($urandom_range(0, 3) != 0);
      WriteReg1 = wa;
      WriteData1 = $urandom;
      #1;
      check_ports("rnd_pre");
      @(posedge CLK);
      if (Write1 && WriteReg1 != 5'd0) model[WriteReg1] = WriteData1;
      #1;
      Write1 = 1'b0;
      #1;
      check_ports("rnd_post");
      @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
